// File: rtl/i_type_control_fsm_if.sv
// Handshake/control-word bundle for i_type_control_fsm.
//   master : control-unit side (drives instr_ready and the control word)
//   slave  : environment side (fetch drives instr/instr_valid, datapath drives cw_ready)
// Signals: instr/instr_valid/instr_ready (fetch handshake), cw_valid/cw_ready
// (datapath handshake), DA/SA/SB/FS/PS/enable/regWrite/memWrite/PC_sel/B_sel/
// status_load/K (control word), illegal (decode fault pulse), retired (count).
interface i_type_control_fsm_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [31:0]           instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  cw_valid;
  logic                  cw_ready;
  logic [4:0]            DA;
  logic [4:0]            SA;
  logic [4:0]            SB;
  logic [4:0]            FS;
  logic [1:0]            PS;
  logic [1:0]            enable;
  logic                  regWrite;
  logic                  memWrite;
  logic                  PC_sel;
  logic                  B_sel;
  logic                  status_load;
  logic [DATA_WIDTH-1:0] K;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  retired;

  modport master (
    input  instr, instr_valid, cw_ready,
    output instr_ready, cw_valid, DA, SA, SB, FS, PS, enable,
           regWrite, memWrite, PC_sel, B_sel, status_load, K, illegal, retired
  );

  modport slave (
    output instr, instr_valid, cw_ready,
    input  instr_ready, cw_valid, DA, SA, SB, FS, PS, enable,
           regWrite, memWrite, PC_sel, B_sel, status_load, K, illegal, retired
  );
endinterface

// File: rtl/i_type_control_fsm.sv
// Multi-cycle control unit for LEGv8 I-format ALU instructions.
// IDLE accepts an instruction (instr_valid & instr_ready), DECODE turns the
// stored word into a registered control word, EXEC presents it (cw_valid=1)
// until the datapath takes it (cw_ready), then retired increments.
// Undecodable opcodes return from DECODE to IDLE with a one-cycle illegal pulse.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : i_type_control_fsm_if.master (handshakes + control word)
// Parameters: DATA_WIDTH (width of K, >= 12), CNT_WIDTH (retired counter width).
// Build option: define ICU_ARITH_EN to also decode ADDI/ADDIS/SUBI/SUBIS.
module i_type_control_fsm #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  i_type_control_fsm_if.master   bus
);

  if (DATA_WIDTH < 12) begin : g_bad_width
    $error("i_type_control_fsm: DATA_WIDTH must be at least 12");
  end

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC
  } state_t;

  state_t      state;
  logic [31:0] instr_q;

  logic [9:0]  opcode;
  logic        dec_legal;
  logic [4:0]  dec_fs;
  logic        dec_sl;

  assign opcode = instr_q[31:22];

  always_comb begin
    dec_legal = 1'b0;
    dec_fs    = '0;
    dec_sl    = 1'b0;
    case (opcode)
      10'b1001001000: begin dec_legal = 1'b1; dec_fs = 5'b00000; dec_sl = 1'b0; end // ANDI
      10'b1011001000: begin dec_legal = 1'b1; dec_fs = 5'b00100; dec_sl = 1'b0; end // ORRI
      10'b1101001000: begin dec_legal = 1'b1; dec_fs = 5'b01100; dec_sl = 1'b0; end // EORI
      10'b1111001000: begin dec_legal = 1'b1; dec_fs = 5'b00000; dec_sl = 1'b1; end // ANDIS
`ifdef ICU_ARITH_EN
      10'b1001000100: begin dec_legal = 1'b1; dec_fs = 5'b01000; dec_sl = 1'b0; end // ADDI
      10'b1011000100: begin dec_legal = 1'b1; dec_fs = 5'b01000; dec_sl = 1'b1; end // ADDIS
      10'b1101000100: begin dec_legal = 1'b1; dec_fs = 5'b01001; dec_sl = 1'b0; end // SUBI
      10'b1111000100: begin dec_legal = 1'b1; dec_fs = 5'b01001; dec_sl = 1'b1; end // SUBIS
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      instr_q         <= '0;
      bus.instr_ready <= 1'b1;
      bus.cw_valid    <= 1'b0;
      bus.DA          <= '0;
      bus.SA          <= '0;
      bus.SB          <= '0;
      bus.FS          <= '0;
      bus.PS          <= '0;
      bus.enable      <= '0;
      bus.regWrite    <= 1'b0;
      bus.memWrite    <= 1'b0;
      bus.PC_sel      <= 1'b0;
      bus.B_sel       <= 1'b0;
      bus.status_load <= 1'b0;
      bus.K           <= '0;
      bus.illegal     <= 1'b0;
      bus.retired     <= '0;
    end else begin
      // illegal is only ever raised for the single edge leaving DECODE
      bus.illegal <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            instr_q         <= bus.instr;
            state           <= DECODE;
            bus.instr_ready <= 1'b0;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            state           <= EXEC;
            bus.cw_valid    <= 1'b1;
            bus.DA          <= instr_q[4:0];
            bus.SA          <= instr_q[9:5];
            bus.SB          <= '0;
            bus.FS          <= dec_fs;
            bus.PS          <= 2'b01;
            bus.enable      <= 2'b01;
            bus.regWrite    <= 1'b1;
            bus.memWrite    <= 1'b0;
            bus.PC_sel      <= 1'b0;
            bus.B_sel       <= 1'b1;
            bus.status_load <= dec_sl;
            bus.K           <= DATA_WIDTH'(instr_q[21:10]);
          end else begin
            state           <= IDLE;
            bus.illegal     <= 1'b1;
            bus.instr_ready <= 1'b1;
          end
        end
        EXEC: begin
          if (bus.cw_ready) begin
            state           <= IDLE;
            bus.instr_ready <= 1'b1;
            bus.cw_valid    <= 1'b0;
            bus.DA          <= '0;
            bus.SA          <= '0;
            bus.FS          <= '0;
            bus.PS          <= '0;
            bus.enable      <= '0;
            bus.regWrite    <= 1'b0;
            bus.B_sel       <= 1'b0;
            bus.status_load <= 1'b0;
            bus.K           <= '0;
            bus.retired     <= bus.retired + CNT_WIDTH'(1);
          end
        end
        default: begin
          state           <= IDLE;
          bus.instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_type_control_fsm.sv
module tb_i_type_control_fsm;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  logic [CW-1:0] exp_ret;

  i_type_control_fsm_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  i_type_control_fsm #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_instr_ready"}, 64'(bus.instr_ready), 64'd1);
    check({tag, "_cw_valid"},    64'(bus.cw_valid),    64'd0);
    check({tag, "_regWrite"},    64'(bus.regWrite),    64'd0);
    check({tag, "_ctrl"}, 64'({bus.DA, bus.SA, bus.SB, bus.FS, bus.PS, bus.enable,
                               bus.memWrite, bus.PC_sel, bus.B_sel, bus.status_load}), 64'd0);
    check({tag, "_K"}, bus.K, 64'd0);
  endtask

  // Issue a legal instruction; datapath stalls for 'hold' EXEC cycles.
  task automatic run_legal(input string tag, input logic [31:0] ins, input logic [4:0] fs,
                           input logic sl, input logic [4:0] da, input logic [4:0] sa,
                           input logic [63:0] k, input int unsigned hold);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.cw_ready    = (hold == 0);
    tick();
    bus.instr_valid = 1'b0;
    check({tag, "_dec_cw_valid"}, 64'(bus.cw_valid),    64'd0);
    check({tag, "_dec_ready"},    64'(bus.instr_ready), 64'd0);
    tick();
    check({tag, "_cw_valid"}, 64'(bus.cw_valid), 64'd1);
    check({tag, "_FS"},       64'(bus.FS), 64'(fs));
    check({tag, "_DA"},       64'(bus.DA), 64'(da));
    check({tag, "_SA"},       64'(bus.SA), 64'(sa));
    check({tag, "_SB"},       64'(bus.SB), 64'd0);
    check({tag, "_K"},        bus.K, k);
    check({tag, "_flags"}, 64'({bus.regWrite, bus.B_sel, bus.memWrite, bus.PC_sel, bus.status_load}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, sl}));
    check({tag, "_PS"},     64'(bus.PS), 64'd1);
    check({tag, "_enable"}, 64'(bus.enable), 64'd1);
    check({tag, "_ready_exec"}, 64'(bus.instr_ready), 64'd0);
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"},   64'(bus.cw_valid), 64'd1);
      check({tag, "_hold_DA"},      64'(bus.DA), 64'(da));
      check({tag, "_hold_retired"}, 64'(bus.retired), 64'(exp_ret));
    end
    bus.cw_ready = 1'b1;
    tick();
    exp_ret = exp_ret + 1'b1;
    check({tag, "_retired"}, 64'(bus.retired), 64'(exp_ret));
    check_idle_outputs({tag, "_after"});
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ins);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.cw_ready    = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check({tag, "_dec_illegal"}, 64'(bus.illegal), 64'd0);
    tick();
    check({tag, "_illegal"},  64'(bus.illegal),     64'd1);
    check({tag, "_cw_valid"}, 64'(bus.cw_valid),    64'd0);
    check({tag, "_ready"},    64'(bus.instr_ready), 64'd1);
    check({tag, "_regWrite"}, 64'(bus.regWrite),    64'd0);
    tick();
    check({tag, "_illegal_drop"}, 64'(bus.illegal),  64'd0);
    check({tag, "_cw_valid2"},    64'(bus.cw_valid), 64'd0);
    check({tag, "_retired"},      64'(bus.retired),  64'(exp_ret));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    exp_ret = '0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.cw_ready = 1'b0;
    reset = 1'b1;

    // reset held for two cycles
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_retired", 64'(bus.retired), 64'd0);
    check("reset_illegal", 64'(bus.illegal), 64'd0);
    reset = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // ANDI, immediate acceptance
    run_legal("andi", 32'h92000401, 5'b00000, 1'b0, 5'd1, 5'd0, 64'd1, 0);
    // ANDIS, datapath stalls three cycles
    run_legal("andis", 32'hF20020C7, 5'b00000, 1'b1, 5'd7, 5'd6, 64'd8, 3);
    // ORRI / EORI with max immediate and registers
    run_legal("orri", {10'b1011001000, 12'hFFF, 5'd31, 5'd30}, 5'b00100, 1'b0, 5'd30, 5'd31, 64'hFFF, 1);
    run_legal("eori", {10'b1101001000, 12'h800, 5'd0, 5'd31}, 5'b01100, 1'b0, 5'd31, 5'd0, 64'h800, 0);

    run_illegal("zero", 32'h00000000);

`ifdef ICU_ARITH_EN
    run_legal("addi", 32'h91001443, 5'b01000, 1'b0, 5'd3, 5'd2, 64'd5, 0);
    run_legal("subis", {10'b1111000100, 12'h00A, 5'd4, 5'd9}, 5'b01001, 1'b1, 5'd9, 5'd4, 64'd10, 0);
`else
    run_illegal("addi", 32'h91001443);
    run_illegal("subis", {10'b1111000100, 12'h00A, 5'd4, 5'd9});
`endif

    // instr_valid held through a whole transaction is not re-accepted mid-flight
    bus.instr = 32'h92000401;
    bus.instr_valid = 1'b1;
    bus.cw_ready = 1'b1;
    tick();
    tick();
    check("nobuf_exec", 64'(bus.cw_valid), 64'd1);
    bus.instr_valid = 1'b0;
    tick();
    exp_ret = exp_ret + 1'b1;
    check("nobuf_retired", 64'(bus.retired), 64'(exp_ret));
    tick();
    check("nobuf_idle", 64'(bus.instr_ready), 64'd1);
    check("nobuf_noexec", 64'(bus.cw_valid), 64'd0);

    // retired counter wraps silently
    while (exp_ret != '1)
      run_legal("wrapfill", 32'h92000401, 5'b00000, 1'b0, 5'd1, 5'd0, 64'd1, 0);
    check("wrap_max", 64'(bus.retired), 64'hF);
    run_legal("wrap", 32'h92000401, 5'b00000, 1'b0, 5'd1, 5'd0, 64'd1, 0);
    check("wrap_zero", 64'(bus.retired), 64'd0);
    run_legal("postwrap", 32'h92000401, 5'b00000, 1'b0, 5'd1, 5'd0, 64'd1, 0);

    // async reset while in EXEC
    bus.instr = 32'hF20020C7;
    bus.instr_valid = 1'b1;
    bus.cw_ready = 1'b0;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    check("rst_exec_valid", 64'(bus.cw_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_cw_valid", 64'(bus.cw_valid),    64'd0);
    check("rst_regWrite", 64'(bus.regWrite),    64'd0);
    check("rst_retired",  64'(bus.retired),     64'd0);
    check("rst_ready",    64'(bus.instr_ready), 64'd1);
    tick();
    reset = 1'b0;
    bus.cw_ready = 1'b1;
    tick();
    tick();
    check_idle_outputs("rst_after");
    exp_ret = '0;
    run_legal("after_rst", 32'h92000401, 5'b00000, 1'b0, 5'd1, 5'd0, 64'd1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
